// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster control inputs and timing outputs of the VGA sync generator.
// Define VGA_FRAME_CNT_EN to add the frame_cnt signal.
interface vga_sync_gen_if #(
  parameter int CNT_W = 10
`ifdef VGA_FRAME_CNT_EN
  , parameter int FRAME_W = 8
`endif
);
  logic en;
  logic pix_en;
  logic hsync;
  logic vsync;
  logic de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic line_start;
  logic frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;
`endif
  modport master (
    input  en, pix_en,
    output hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , frame_cnt
`endif
  );
  modport slave (
    output en, pix_en,
    input  hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , frame_cnt
`endif
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator (x/y counters, syncs, de, line/frame strobes).
// Define VGA_FRAME_CNT_EN to add a wrapping frame counter.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10
`ifdef VGA_FRAME_CNT_EN
  , parameter int FRAME_W = 8
`endif
) (
  input logic clk,
  input logic rst_n,
  vga_sync_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

  function automatic logic in_rng(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return int'(v) >= lo && int'(v) < hi;
  endfunction

  logic adv, x_wrap, y_wrap;
  logic [CNT_W-1:0] x_n, y_n;
  logic hs_n, vs_n, de_n, ls_n, fs_n;

  // Levels decode the next-state counters so they line up with x/y; pix_en=0 holds them.
  always_comb begin
    adv    = bus.en && bus.pix_en;
    x_wrap = bus.x == X_LAST;
    y_wrap = bus.y == Y_LAST;
    x_n    = !bus.en ? '0 : !bus.pix_en ? bus.x : x_wrap ? '0 : bus.x + 1'b1;
    y_n    = !bus.en ? '0 : !(adv && x_wrap) ? bus.y : y_wrap ? '0 : bus.y + 1'b1;
    de_n   = !bus.en ? 1'b0 : !bus.pix_en ? bus.de : in_rng(x_n, 0, H_ACTIVE) && in_rng(y_n, 0, V_ACTIVE);
    hs_n   = !bus.en ? ~H_POL : !bus.pix_en ? bus.hsync : in_rng(x_n, HS_LO, HS_HI) ? H_POL : ~H_POL;
    vs_n   = !bus.en ? ~V_POL : !bus.pix_en ? bus.vsync : in_rng(y_n, VS_LO, VS_HI) ? V_POL : ~V_POL;
    ls_n   = adv && x_wrap;
    fs_n   = ls_n && y_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.x           <= '0;
      bus.y           <= '0;
      bus.de          <= 1'b0;
      bus.hsync       <= ~H_POL;
      bus.vsync       <= ~V_POL;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.x           <= x_n;
      bus.y           <= y_n;
      bus.de          <= de_n;
      bus.hsync       <= hs_n;
      bus.vsync       <= vs_n;
      bus.line_start  <= ls_n;
      bus.frame_start <= fs_n;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.frame_cnt <= '0;
    else bus.frame_cnt <= !bus.en ? '0 : fs_n ? bus.frame_cnt + 1'b1 : bus.frame_cnt;
  end
`endif
endmodule
